// File: rtl/spi_flash_pkg.sv
// Shared opcodes, widths, state encoding and JEDEC byte selector for the SPI flash responder.
package spi_flash_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_BITS = 24;
    localparam int unsigned CNT_W     = 5;

    localparam logic [BYTE_W-1:0] CMD_READ      = 8'h03;
    localparam logic [BYTE_W-1:0] CMD_FAST_READ = 8'h0B;
    localparam logic [BYTE_W-1:0] CMD_RDID      = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_ID,
        ST_IGNORE
    } state_t;

    // Select one of the three ID bytes (MSB byte first); anything past the ID reads as zero.
    function automatic logic [BYTE_W-1:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = id[23:16];
            2'd1:    id_byte = id[15:8];
            2'd2:    id_byte = id[7:0];
            default: id_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus rise/fall detection on the synchronized level.
module spi_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronizer chain with one extra stage for edge detection; idles low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI (mode 0) flash-read responder: READ, FAST READ and JEDEC ID, served from a byte memory.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata
);

    logic              sclk_rise_c;
    logic              sclk_fall_c;
    logic              cs_meta;
    logic              cs_s;
    logic              mosi_meta;
    logic              mosi_s;
    logic [1:0]        sync_ok;
    logic              armed;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_BITS-2:0] in_sh;
    logic              fast;
    logic [BYTE_W-1:0] sh_out;
    logic [BYTE_W-1:0] pf_buf;
    logic              rd_q;
    logic              rd_to_sh;
    logic [1:0]        id_idx;

    spi_sync_edge u_sclk_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (spi_clk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // cs_n/mosi synchronizers; arm only once cs_n has really been seen high after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cs_meta   <= 1'b1;
            cs_s      <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
            sync_ok   <= 2'b00;
            armed     <= 1'b0;
        end else begin
            cs_meta   <= spi_cs_n;
            cs_s      <= cs_meta;
            mosi_meta <= spi_mosi;
            mosi_s    <= mosi_meta;
            sync_ok   <= {sync_ok[0], 1'b1};
            if (sync_ok[1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Transaction FSM: command decode, address capture, memory read/prefetch and MISO shifting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            in_sh    <= '0;
            fast     <= 1'b0;
            sh_out   <= '0;
            pf_buf   <= '0;
            rd_q     <= 1'b0;
            rd_to_sh <= 1'b0;
            id_idx   <= 2'd0;
            spi_miso <= 1'b0;
            miso_oe  <= 1'b0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            rd_q   <= mem_rd;
            if (state != ST_IDLE && cs_s) begin
                // Deselect aborts everything, including a read still in flight.
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                rd_q     <= 1'b0;
                spi_miso <= 1'b0;
                miso_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        spi_miso <= 1'b0;
                        miso_oe  <= 1'b0;
                        if (armed && !cs_s) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise_c) begin
                            in_sh <= {in_sh[ADDR_BITS-3:0], mosi_s};
                            if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                                bit_cnt <= '0;
                                fast    <= ({in_sh[6:0], mosi_s} == CMD_FAST_READ);
                                case ({in_sh[6:0], mosi_s})
                                    CMD_READ, CMD_FAST_READ: state <= ST_ADDR;
                                    CMD_RDID: begin
                                        state   <= ST_ID;
                                        sh_out  <= id_byte(JEDEC_ID, 2'd0);
                                        id_idx  <= 2'd1;
                                        miso_oe <= 1'b1;
                                    end
                                    default: state <= ST_IGNORE;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise_c) begin
                            in_sh <= {in_sh[ADDR_BITS-3:0], mosi_s};
                            if (bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                                bit_cnt  <= '0;
                                mem_addr <= ADDR_W'({in_sh, mosi_s});
                                if (fast) begin
                                    state <= ST_DUMMY;
                                end else begin
                                    state    <= ST_DATA;
                                    mem_rd   <= 1'b1;
                                    rd_to_sh <= 1'b1;
                                    miso_oe  <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sclk_rise_c) begin
                            if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                                bit_cnt  <= '0;
                                state    <= ST_DATA;
                                mem_rd   <= 1'b1;
                                rd_to_sh <= 1'b1;
                                miso_oe  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        // First read fills the shift register and chains the prefetch; later ones fill the buffer.
                        if (rd_q) begin
                            if (rd_to_sh) begin
                                sh_out   <= mem_rdata;
                                mem_addr <= mem_addr + ADDR_W'(1);
                                mem_rd   <= 1'b1;
                                rd_to_sh <= 1'b0;
                            end else begin
                                pf_buf <= mem_rdata;
                            end
                        end
                        if (sclk_fall_c) begin
                            spi_miso <= sh_out[BYTE_W-1];
                        end
                        if (sclk_rise_c) begin
                            if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                                bit_cnt  <= '0;
                                sh_out   <= pf_buf;
                                mem_addr <= mem_addr + ADDR_W'(1);
                                mem_rd   <= 1'b1;
                                rd_to_sh <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                                sh_out  <= {sh_out[BYTE_W-2:0], 1'b0};
                            end
                        end
                    end
                    ST_ID: begin
                        if (sclk_fall_c) begin
                            spi_miso <= sh_out[BYTE_W-1];
                        end
                        if (sclk_rise_c) begin
                            if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                                bit_cnt <= '0;
                                sh_out  <= id_byte(JEDEC_ID, id_idx);
                                if (id_idx != 2'd3) begin
                                    id_idx <= id_idx + 2'd1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                                sh_out  <= {sh_out[BYTE_W-2:0], 1'b0};
                            end
                        end
                    end
                    ST_IGNORE: begin
                        miso_oe  <= 1'b0;
                        spi_miso <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized + directed bench for spi_flash_responder against a byte-level transaction model.
module tb_spi_flash_responder;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned HALF   = 8;
    localparam logic [23:0] JID    = 24'hEF4016;

    logic              clk = 1'b0;
    logic              resetn;
    logic              spi_clk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [7:0]        tx_buf [0:15];
    logic [7:0]        rx_buf [0:15];
    logic [ADDR_W-1:0] rd_addr_q [$];
    bit                ignore_mode = 1'b0;
    int                cs_high_cnt = 0;
    logic              prev_rd = 1'b0;

    spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(JID)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .miso_oe   (miso_oe),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing memory: data valid the cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle rules that must hold whatever the transaction.
    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            prev_rd     = 1'b0;
            cs_high_cnt = 0;
        end else begin
            cs_high_cnt = spi_cs_n ? cs_high_cnt + 1 : 0;
            check("miso_zero_when_not_oe", {31'd0, (!miso_oe && spi_miso !== 1'b0)}, 32'd0);
            check("mem_rd_single_pulse", {31'd0, (mem_rd && prev_rd)}, 32'd0);
            if (cs_high_cnt > 4) check("deselected_quiet", {30'd0, miso_oe, mem_rd}, 32'd0);
            if (ignore_mode) check("ignore_no_oe", {31'd0, miso_oe}, 32'd0);
            if (mem_rd) rd_addr_q.push_back(mem_addr);
            prev_rd = mem_rd;
        end
    end

    // Mode-0 master: shift nbits of tx_buf out MSB first, capture MISO on each rising edge.
    task automatic spi_bits(input int nbits, input bit release_cs);
        for (int b = 0; b < 16; b++) rx_buf[b] = 8'h00;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx_buf[i/8][7 - (i%8)];
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            rx_buf[i/8][7 - (i%8)] = spi_miso;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
        if (release_cs) begin
            repeat (HALF) @(negedge clk);
            spi_cs_n = 1'b1;
            spi_mosi = 1'b0;
            repeat (4*HALF) @(negedge clk);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [23:0] a, input int i);
        logic [ADDR_W-1:0] ea;
        ea = ADDR_W'(a + 24'(i));
        return mem[ea];
    endfunction

    function automatic logic [7:0] model_id(input int i);
        logic [23:0] id;
        id = JID;
        if (i == 0) return id[23:16];
        if (i == 1) return id[15:8];
        if (i == 2) return id[7:0];
        return 8'h00;
    endfunction

    // Read transaction; returns header length so callers can locate data bytes in rx_buf.
    task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int nbytes,
                           input int extra_bits, input bit release_cs, output int hdr);
        tx_buf[0] = op;
        tx_buf[1] = a[23:16];
        tx_buf[2] = a[15:8];
        tx_buf[3] = a[7:0];
        tx_buf[4] = 8'h00;
        hdr = (op == 8'h0B) ? 5 : 4;
        for (int k = hdr; k < 16; k++) tx_buf[k] = 8'($urandom);
        rd_addr_q.delete();
        spi_bits(hdr*8 + nbytes*8 + extra_bits, release_cs);
    endtask

    // Model-based check of read data and the sequence of memory read addresses.
    task automatic check_read(input string name, input logic [23:0] a, input int nbytes, input int hdr);
        logic [ADDR_W-1:0] ea;
        for (int i = 0; i < nbytes; i++)
            check({name, "_data"}, {24'd0, rx_buf[hdr+i]}, {24'd0, model_byte(a, i)});
        check({name, "_rd_count"}, rd_addr_q.size(), nbytes + 2);
        for (int k = 0; k < rd_addr_q.size(); k++) begin
            ea = ADDR_W'(a + 24'(k));
            check({name, "_rd_addr"}, {16'd0, rd_addr_q[k]}, {16'd0, ea});
        end
    endtask

    initial begin
        int hdr;
        int kind, nbytes, extra;
        logic [23:0] a;
        logic [7:0] op;

        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'(i);
        resetn   = 1'b0;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("reset_spi_miso", {31'd0, spi_miso}, 32'd0);
        check("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        resetn = 1'b1;
        repeat (4*HALF) @(negedge clk);

        // READ 0x000010, 4 bytes
        do_read(8'h03, 24'h000010, 4, 0, 1'b1, hdr);
        check("read_b0", {24'd0, rx_buf[4]}, 32'h10);
        check("read_b1", {24'd0, rx_buf[5]}, 32'h11);
        check("read_b2", {24'd0, rx_buf[6]}, 32'h12);
        check("read_b3", {24'd0, rx_buf[7]}, 32'h13);
        check_read("read", 24'h000010, 4, hdr);

        // FAST READ 0x0000FE, 3 bytes
        do_read(8'h0B, 24'h0000FE, 3, 0, 1'b1, hdr);
        check("fast_b0", {24'd0, rx_buf[5]}, 32'hFE);
        check("fast_b1", {24'd0, rx_buf[6]}, 32'hFF);
        check("fast_b2", {24'd0, rx_buf[7]}, 32'h00);
        check_read("fast", 24'h0000FE, 3, hdr);

        // READ with address wrap at 0xFFFF
        do_read(8'h03, 24'h00FFFF, 2, 0, 1'b1, hdr);
        check("wrap_b0", {24'd0, rx_buf[4]}, 32'hFF);
        check("wrap_b1", {24'd0, rx_buf[5]}, 32'h00);
        check_read("wrap", 24'h00FFFF, 2, hdr);

        // JEDEC ID then an unsupported opcode
        tx_buf[0] = 8'h9F;
        for (int k = 1; k < 16; k++) tx_buf[k] = 8'h00;
        rd_addr_q.delete();
        spi_bits(40, 1'b1);
        check("id_b0", {24'd0, rx_buf[1]}, 32'hEF);
        check("id_b1", {24'd0, rx_buf[2]}, 32'h40);
        check("id_b2", {24'd0, rx_buf[3]}, 32'h16);
        check("id_b3", {24'd0, rx_buf[4]}, 32'h00);
        check("id_no_reads", rd_addr_q.size(), 0);
        ignore_mode = 1'b1;
        tx_buf[0] = 8'hAB;
        spi_bits(32, 1'b1);
        ignore_mode = 1'b0;
        check("ignore_rx", {rx_buf[1], rx_buf[2], rx_buf[3]}, 32'd0);
        check("ignore_no_reads", rd_addr_q.size(), 0);

        // Abort 3 bits into the 2nd data byte, then a clean READ
        do_read(8'h03, 24'h000040, 1, 3, 1'b1, hdr);
        check("abort_b0", {24'd0, rx_buf[4]}, 32'h40);
        check("abort_rd_count", rd_addr_q.size(), 3);
        do_read(8'h03, 24'h000020, 1, 0, 1'b1, hdr);
        check("after_abort_b0", {24'd0, rx_buf[4]}, 32'h20);
        check_read("after_abort", 24'h000020, 1, hdr);

        // Reset mid-DATA, then ignore the still-selected transaction, then a clean READ
        do_read(8'h03, 24'h000030, 1, 4, 1'b0, hdr);
        check("pre_reset_b0", {24'd0, rx_buf[4]}, 32'h30);
        resetn = 1'b0;
        #1;
        check("reset_async_oe", {31'd0, miso_oe}, 32'd0);
        check("reset_async_rd", {31'd0, mem_rd}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        rd_addr_q.delete();
        ignore_mode = 1'b1;
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h30;
        spi_bits(48, 1'b0);
        ignore_mode = 1'b0;
        check("post_reset_ignored_reads", rd_addr_q.size(), 0);
        check("post_reset_ignored_rx", {rx_buf[4], rx_buf[5]}, 32'd0);
        spi_cs_n = 1'b1;
        repeat (4*HALF) @(negedge clk);
        do_read(8'h03, 24'h000030, 2, 0, 1'b1, hdr);
        check("post_reset_b0", {24'd0, rx_buf[4]}, 32'h30);
        check("post_reset_b1", {24'd0, rx_buf[5]}, 32'h31);
        check_read("post_reset", 24'h000030, 2, hdr);

        // Randomized transactions against the model
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 20; t++) begin
            kind   = int'($urandom_range(0, 3));
            a      = 24'($urandom);
            nbytes = int'($urandom_range(1, 5));
            extra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            if (kind == 0 || kind == 1) begin
                do_read((kind == 0) ? 8'h03 : 8'h0B, a, nbytes, extra, 1'b1, hdr);
                check_read("rand_read", a, nbytes, hdr);
            end else if (kind == 2) begin
                tx_buf[0] = 8'h9F;
                for (int k = 1; k < 16; k++) tx_buf[k] = 8'($urandom);
                rd_addr_q.delete();
                spi_bits(8 + nbytes*8 + extra, 1'b1);
                for (int j = 0; j < nbytes; j++)
                    check("rand_id", {24'd0, rx_buf[1+j]}, {24'd0, model_id(j)});
                check("rand_id_no_reads", rd_addr_q.size(), 0);
            end else begin
                do begin
                    op = 8'($urandom);
                end while (op == 8'h03 || op == 8'h0B || op == 8'h9F);
                tx_buf[0] = op;
                for (int k = 1; k < 16; k++) tx_buf[k] = 8'($urandom);
                rd_addr_q.delete();
                ignore_mode = 1'b1;
                spi_bits(8 + nbytes*8 + extra, 1'b1);
                ignore_mode = 1'b0;
                for (int j = 0; j < nbytes; j++)
                    check("rand_ignore_rx", {24'd0, rx_buf[1+j]}, 32'd0);
                check("rand_ignore_no_reads", rd_addr_q.size(), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the memory byte-address width; the upper 24-ADDR_W SPI address bits are ignored.
REQ-002 SHALL have parameter JEDEC_ID, default 24'hEF4016, meaning the 3-byte ID returned by command 0x9F, MSB byte first.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port spi_clk  input  1  SPI serial clock from the master (mode 0); asynchronous to clk, frequency at most clk/8.
REQ-006 SHALL have port spi_cs_n  input  1  active-low chip select.
REQ-007 SHALL have port spi_mosi  input  1  serial data from the master.
REQ-008 SHALL have port spi_miso  output  1  serial data to the master.
REQ-009 SHALL have port miso_oe  output  1  spi_miso output enable, for the top-level tristate.
REQ-010 SHALL have port mem_addr  output  ADDR_W  byte address of the backing memory.
REQ-011 SHALL have port mem_rd  output  1  one-cycle read strobe.
REQ-012 SHALL have port mem_rdata  input  8  read data, valid exactly one clk after mem_rd.

Function
REQ-013 SHALL pass spi_clk, spi_cs_n and spi_mosi through 2-flop synchronizers and detect spi_clk rising and falling edges on the synchronized signal.
REQ-014 SHALL sample spi_mosi on detected rising edges and drive spi_miso on detected falling edges, MSB first.
REQ-015 SHALL implement the states IDLE, CMD, ADDR, DUMMY, DATA, ID and IGNORE.
REQ-016 SHALL move from IDLE to CMD when synchronized spi_cs_n falls, with the bit counter cleared.
REQ-017 SHALL, after 8 command bits, go to ADDR for 0x03 or 0x0B, to ID for 0x9F, and to IGNORE for any other command.
REQ-018 SHALL, after 24 address bits, go to DATA for 0x03, or to DUMMY for 0x0B, where it SHALL skip 8 spi_clk cycles before entering DATA.
REQ-019 SHALL, on entering DATA, pulse mem_rd for the start address, load the byte into the output shift register, then immediately prefetch address+1 into an 8-bit buffer.
REQ-020 SHALL, at each byte boundary, load the shift register from the prefetch buffer and prefetch the next address; addresses SHALL wrap from 2^ADDR_W-1 to 0.
REQ-021 SHALL have the first data bit valid on spi_miso before the first spi_clk rising edge of the data phase.
REQ-022 SHALL, in ID, shift out the 3 JEDEC_ID bytes, then repeat 0x00 until deselect.
REQ-023 SHALL, in IGNORE, leave miso_oe=0 and ignore all spi_clk edges.
REQ-024 SHALL return to IDLE from any state when synchronized spi_cs_n rises, including mid-byte, and abort any partial transfer; a pending prefetch SHALL be discarded.
REQ-025 SHALL assert miso_oe only in DATA and ID while spi_cs_n is low, and drive spi_miso=0 whenever miso_oe=0.
REQ-026 SHALL keep mem_rd low except for single-cycle pulses, and issue at most one pulse per byte boundary.

Reset
REQ-027 SHALL, while resetn=0, force: state IDLE, spi_miso=0, miso_oe=0, mem_rd=0, mem_addr=0, counters and shift registers 0, synchronizers to idle levels (spi_cs_n=1, spi_clk=0).
REQ-028 SHALL ignore any transaction already in progress when resetn is released until spi_cs_n has been observed high.

Structure
REQ-029 SHALL place the command opcodes (0x03, 0x0B, 0x9F) and the state encoding in a shared package spi_flash_pkg.
REQ-030 SHALL implement the synchronizer and edge detector as the sub-module spi_sync_edge, instantiated once for spi_clk; cs_n and mosi SHALL use plain 2-flop synchronizers.

Verification
REQ-031 SHALL test: memory byte[i]=i; READ 0x03 at address 0x000010, 4 bytes -> MISO returns 0x10,0x11,0x12,0x13.
REQ-032 SHALL test: FAST READ 0x0B at address 0x0000FE, 8 dummy cycles, 3 bytes -> MISO returns 0xFE,0xFF,0x00 for a memory byte[i]=i[7:0].
REQ-033 SHALL test: READ at 0x00FFFF with ADDR_W=16, 2 bytes -> byte[0xFFFF] then byte[0x0000] (wrap).
REQ-034 SHALL test: 0x9F, 4 bytes -> 0xEF,0x40,0x16,0x00; then opcode 0xAB -> miso_oe stays 0 for the whole transaction.
REQ-035 SHALL test: spi_cs_n raised after 3 bits of the 2nd data byte, then a READ at 0x000020 -> the 2nd transaction returns byte[0x20] correctly, with no mem_rd pulses while deselected.
REQ-036 SHALL test: resetn asserted mid-DATA -> miso_oe=0 and mem_rd=0 immediately; after release, a new READ completes correctly.
